// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO for the EX stage.
// Optional madd (op=4) is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = ($clog2(MAX_LAT + 1) > 4) ? $clog2(MAX_LAT + 1) : 4;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      shadow_hi_q, shadow_hi_d;
  logic [31:0]      shadow_lo_q, shadow_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        op_legal;
  logic [63:0] prod_u, prod_s, res;
  logic [31:0] div_u, quot_u, rem_u;
  logic [31:0] a_mag, b_mag, div_s, quot_mag, rem_mag, quot_s, rem_s;

  always_comb begin
`ifdef MD_MADD_EN
    op_legal = (op <= 3'd4);
`else
    op_legal = (op <= 3'd3);
`endif
  end

  assign prod_u = {32'd0, a} * {32'd0, b};
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

  // Divisors are forced nonzero so the dividers never see /0; the b==0 case is handled in the mux.
  assign div_u  = (b == 32'd0) ? 32'd1 : b;
  assign quot_u = a / div_u;
  assign rem_u  = a % div_u;

  // Signed divide on magnitudes: 0x80000000 stays 0x80000000 as an unsigned magnitude.
  assign a_mag    = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b[31] ? (~b + 32'd1) : b;
  assign div_s    = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign quot_mag = a_mag / div_s;
  assign rem_mag  = a_mag % div_s;
  assign quot_s   = (a[31] ^ b[31]) ? (~quot_mag + 32'd1) : quot_mag;
  assign rem_s    = a[31] ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    res = {hi_q, lo_q};
    case (op)
      3'd0: res = prod_u;
      3'd1: res = prod_s;
      3'd2: if (b != 32'd0) res = {rem_u, quot_u};
      3'd3: if (b != 32'd0) res = {rem_s, quot_s};
`ifdef MD_MADD_EN
      3'd4: res = prod_s + {hi_q, lo_q};
`endif
      default: res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    case (state_q)
      IDLE: begin
        if (start && op_legal) begin
          state_d     = RUN;
          cnt_d       = op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
          shadow_hi_d = res[63:32];
          shadow_lo_d = res[31:0];
        end else begin
          if (we_hi) hi_d = wdata;
          if (we_lo) lo_d = wdata;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = shadow_hi_q;
          lo_d    = shadow_lo_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomized bench for md_unit against a cycle-count reference model.
module tb_md_unit;
  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        we_hi = 1'b0, we_lo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;
  bit run_chk = 1'b0;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  int          m_rem = 0;

  md_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit legal(input logic [2:0] o);
`ifdef MD_MADD_EN
    return o <= 3'd4;
`else
    return o <= 3'd3;
`endif
  endfunction

  function automatic logic [63:0] md_result(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [31:0] h,
                                            input logic [31:0] l);
    longint unsigned ux, uy;
    longint          sx, sy, q, r, p;
    ux = {32'd0, x};
    uy = {32'd0, y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: return ux * uy;
      3'd1: begin p = sx * sy; return p; end
      3'd2: begin
        if (y == 32'd0) return {h, l};
        return {x % y, x / y};
      end
      3'd3: begin
        if (y == 32'd0) return {h, l};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin p = sx * sy + longint'({h, l}); return p; end
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_edge();
    logic [63:0] r;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start && legal(op)) begin
      r = md_result(op, a, b, m_hi, m_lo);
      p_hi = r[63:32];
      p_lo = r[31:0];
      m_rem = (op == 3'd2 || op == 3'd3) ? DL : ML;
    end else begin
      if (we_hi) m_hi = wdata;
      if (we_lo) m_lo = wdata;
    end
  endtask

  task automatic cyc(input bit s, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                     input bit wh, input bit wl, input logic [31:0] wd);
    start = s; op = o; a = av; b = bv; we_hi = wh; we_lo = wl; wdata = wd;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output int n);
    cyc(1'b1, o, av, bv, 1'b0, 1'b0, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      idle();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run_chk && reset_n) begin
      chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  initial begin
    int n;
    bit s, wh, wl;
    logic [2:0] o;
    #2;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    #1 reset_n = 1'b1;
    run_chk = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_lat", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_lat", 32'(n), 32'd10);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);

    run_op(3'd2, 32'd7, 32'd0, n);
    chk("divz_lat", 32'(n), 32'd10);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);

    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("divovf_hi", hi, 32'd0);
    chk("divovf_lo", lo, 32'h8000_0000);

    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h5678);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h1234);
    chk("mtlo_lo", lo, 32'h5678);

    cyc(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; idle(); end
    chk("wlo_busy_hi", hi, 32'd0);
    chk("wlo_busy_lo", lo, 32'd12);

    cyc(1'b1, 3'd2, 32'd100, 32'd7, 1'b1, 1'b0, 32'hFFFF);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      cyc(n == 3, 3'd1, 32'd5, 32'd5, 1'b0, 1'b0, 32'd0);
    end
    chk("divu_lat", 32'(n), 32'd10);
    chk("divu_hi", hi, 32'd2);
    chk("divu_lo", lo, 32'd14);

    cyc(1'b1, 3'd3, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) idle();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
    reset_n = 1'b1;
    idle();

`ifdef MD_MADD_EN
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    cyc(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_op(3'd4, 32'd1, 32'd1, n);
    chk("madd_lat", 32'(n), 32'd5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
`endif

    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      o  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      wh = ($urandom_range(0, 4) == 0);
      wl = ($urandom_range(0, 4) == 0);
      cyc(s, o, pick(), pick(), wh, wl, $urandom);
    end
    for (int i = 0; i < 12; i++) idle();

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
